// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver:
//   - rx_state_e : receiver FSM state encoding
//   - PARITY_*   : parity mode constants for the PARITY_MODE parameter
//   - mid_count  : the centre count M of a bit period
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Centre of a bit; the vote window is M-1, M, M+1.
  function automatic int mid_count(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser plus 3-sample majority voter.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   serial      : raw asynchronous RX line
//   count       : position inside the current bit period (from the FSM)
//   line        : synchronised line (second flop)
//   vote        : majority of samples at M-1, M and the current line at M+1
//   decide      : high while count == M+1 (vote is meaningful)
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial,
  input  logic [CNT_W-1:0] count,
  output logic             line,
  output logic             vote,
  output logic             decide
);

  localparam int              M     = mid_count(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_LO  = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] C_MID = CNT_W'(M);
  localparam logic [CNT_W-1:0] C_HI  = CNT_W'(M + 1);

  logic sync_1, sync_2;
  logic s_lo, s_mid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      s_lo   <= 1'b1;
      s_mid  <= 1'b1;
    end else begin
      sync_1 <= serial;
      sync_2 <= sync_1;
      if (count == C_LO)  s_lo  <= sync_2;
      if (count == C_MID) s_mid <= sync_2;
    end
  end

  // Third sample is taken live at M+1 so the decision lands in the same cycle.
  assign line   = sync_2;
  assign vote   = (s_lo & s_mid) | (s_lo & sync_2) | (s_mid & sync_2);
  assign decide = (count == C_HI);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (data width, parity, stop bits) with
// majority-voted sampling and parity / framing / break reporting.
// Ports:
//   i_Clock, i_Reset_n : clock, async active-low reset
//   i_Rx_Serial        : serial input, idles high
//   o_Rx_DV            : one-cycle frame-complete pulse
//   o_Rx_Active        : high while a frame is in progress
//   o_Rx_Byte          : received data (held until next o_Rx_DV)
//   o_Parity_Err, o_Frame_Err, o_Break : status of the last frame
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic                 o_Rx_Active,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int               IDX_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  rx_state_e            state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic                 stop_idx, stop_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, par_q, par_d;
  logic                 brk_d, done;
  logic                 line, vote, decide;

  uart_rx_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_sampler (
    .clk    (i_Clock),
    .rst_n  (i_Reset_n),
    .serial (i_Rx_Serial),
    .count  (cnt),
    .line   (line),
    .vote   (vote),
    .decide (decide)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      idx          <= '0;
      stop_idx     <= 1'b0;
      data_q       <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      par_q        <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      idx      <= idx_d;
      stop_idx <= stop_d;
      data_q   <= data_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      par_q    <= par_d;
      o_Rx_DV  <= done;
      if (done) begin
        o_Rx_Byte    <= data_q;
        o_Parity_Err <= perr_q;
        o_Frame_Err  <= ferr_d;
        o_Break      <= brk_d;
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CNT_W'(1);
    idx_d   = idx;
    stop_d  = stop_idx;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    par_d   = par_q;
    done    = 1'b0;
    // Break looks at the final stop sample; only used when done is high.
    brk_d   = (data_q == '0) && !par_q && !vote;
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (!line) state_d = ST_START;
      end
      ST_START: begin
        if (decide && vote) begin
          state_d = ST_IDLE;          // false start
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          idx_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          par_d   = 1'b0;
        end
      end
      ST_DATA: begin
        if (decide) data_d[idx] = vote;
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          if (idx == IDX_LAST) begin
            state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            stop_d  = 1'b0;
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (decide) begin
          par_d  = vote;
          perr_d = (PARITY_MODE == PARITY_ODD) ? ~(^data_q ^ vote) : (^data_q ^ vote);
        end
        if (cnt == CNT_LAST) begin
          state_d = ST_STOP;
          cnt_d   = '0;
          stop_d  = 1'b0;
        end
      end
      ST_STOP: begin
        if (decide && !vote) ferr_d = 1'b1;
        // Final stop bit completes at its decision point for half-bit resync margin.
        if (decide && stop_idx == STOP_LAST) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = vote ? ST_IDLE : ST_BRK_WAIT;
        end else if (cnt == CNT_LAST) begin
          cnt_d  = '0;
          stop_d = 1'b1;
        end
      end
      ST_BRK_WAIT: begin
        cnt_d = '0;
        if (line) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_Rx_Active = (state == ST_START) || (state == ST_DATA) ||
                       (state == ST_PARITY) || (state == ST_STOP);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) at 16 clocks/bit,
// directed scenarios plus random frames checked against a frame-level model.
module tb_uart_rx_cfg;

  localparam int CPB = 16;
  localparam int M   = (CPB - 1) / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rx;
  always #5 clk = ~clk;

  logic       dv_a, act_a, pe_a, fe_a, bk_a;
  logic       dv_b, act_b, pe_b, fe_b, bk_b;
  logic       dv_c, act_c, pe_c, fe_c, bk_c;
  logic [7:0] byte_a, byte_c;
  logic [6:0] byte_b;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv_a),
    .o_Rx_Active(act_a), .o_Rx_Byte(byte_a), .o_Parity_Err(pe_a),
    .o_Frame_Err(fe_a), .o_Break(bk_a));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) dut_b (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv_b),
    .o_Rx_Active(act_b), .o_Rx_Byte(byte_b), .o_Parity_Err(pe_b),
    .o_Frame_Err(fe_b), .o_Break(bk_b));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) dut_c (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv_c),
    .o_Rx_Active(act_c), .o_Rx_Byte(byte_c), .o_Parity_Err(pe_c),
    .o_Frame_Err(fe_c), .o_Break(bk_c));

  int cmp = 0, err = 0;
  int cyc = 0, start_cyc = 0;
  int dv_cnt[3], dv_cyc[3];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dv_a) begin dv_cnt[0]++; dv_cyc[0] = cyc; end
    if (dv_b) begin dv_cnt[1]++; dv_cyc[1] = cyc; end
    if (dv_c) begin dv_cnt[2]++; dv_cyc[2] = cyc; end
  end

  function automatic int nd_of(int sel); return (sel == 1) ? 7 : 8; endfunction
  function automatic int pm_of(int sel); return (sel == 1) ? 2 : 0; endfunction
  function automatic int ns_of(int sel); return (sel == 2) ? 2 : 1; endfunction

  // Line levels of one frame, bit 0 first on the wire.
  function automatic logic [15:0] mk_frame(int sel, logic [8:0] d, logic pb, logic [1:0] st,
                                           output int n);
    logic [15:0] lv;
    int pos;
    lv = '1;
    lv[0] = 1'b0;
    for (int i = 0; i < nd_of(sel); i++) lv[1+i] = d[i];
    pos = 1 + nd_of(sel);
    if (pm_of(sel) != 0) begin lv[pos] = pb; pos++; end
    for (int s = 0; s < ns_of(sel); s++) lv[pos+s] = st[s];
    n = pos + ns_of(sel);
    return lv;
  endfunction

  // Expected result of a frame, derived from its line levels.
  function automatic void ref_frame(int sel, logic [15:0] lv, output logic [8:0] d,
                                    output logic pe, output logic fe, output logic bk);
    int pos;
    logic p, last;
    d = '0; p = 1'b0; pe = 1'b0; fe = 1'b0;
    for (int i = 0; i < nd_of(sel); i++) d[i] = lv[1+i];
    pos = 1 + nd_of(sel);
    if (pm_of(sel) != 0) begin
      p  = lv[pos];
      pe = (pm_of(sel) == 1) ? ((^d ^ p) == 1'b0) : ((^d ^ p) == 1'b1);
      pos++;
    end
    for (int s = 0; s < ns_of(sel); s++) if (!lv[pos+s]) fe = 1'b1;
    last = lv[pos + ns_of(sel) - 1];
    bk = (d == '0) && !p && !last;
  endfunction

  task automatic get_out(input int sel, output logic [8:0] d, output logic pe,
                         output logic fe, output logic bk, output logic act);
    case (sel)
      0:       begin d = {1'b0, byte_a}; pe = pe_a; fe = fe_a; bk = bk_a; act = act_a; end
      1:       begin d = {2'b0, byte_b}; pe = pe_b; fe = fe_b; bk = bk_b; act = act_b; end
      default: begin d = {1'b0, byte_c}; pe = pe_c; fe = fe_c; bk = bk_c; act = act_c; end
    endcase
  endtask

  // Drives n bit periods; optionally inverts one clock at (gbit, gpos).
  task automatic send_frame(input int sel, input logic [15:0] lv, input int n,
                            input int gbit, input int gpos);
    for (int b = 0; b < n; b++)
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        rx[sel] = lv[b] ^ ((b == gbit) && (c == gpos));
        if (b == 0 && c == 0) start_cyc = cyc + 1;
      end
  endtask

  task automatic idle(input int sel, input int clocks);
    for (int c = 0; c < clocks; c++) begin @(negedge clk); rx[sel] = 1'b1; end
  endtask

  // Sends a frame, then checks pulse count and outputs against the model.
  task automatic frame_check(input string name, input int sel, input logic [15:0] lv,
                             input int n, input int gbit);
    int base;
    logic [8:0] ed, d;
    logic epe, efe, ebk, pe, fe, bk, act;
    base = dv_cnt[sel];
    send_frame(sel, lv, n, gbit, M);
    idle(sel, 2 * CPB);
    ref_frame(sel, lv, ed, epe, efe, ebk);
    get_out(sel, d, pe, fe, bk, act);
    cmp++;
    if (dv_cnt[sel] - base !== 1) begin
      err++; $display("FAIL %s dv_count: got %0d want 1", name, dv_cnt[sel] - base);
    end
    cmp++;
    if ({d, pe, fe, bk} !== {ed, epe, efe, ebk}) begin
      err++;
      $display("FAIL %s outputs: got byte=%h pe=%b fe=%b brk=%b want byte=%h pe=%b fe=%b brk=%b",
               name, d, pe, fe, bk, ed, epe, efe, ebk);
    end
  endtask

  task automatic check_all_zero(input string name);
    cmp++;
    if ({dv_a, act_a, byte_a, pe_a, fe_a, bk_a, dv_b, act_b, byte_b, pe_b, fe_b, bk_b,
         dv_c, act_c, byte_c, pe_c, fe_c, bk_c} !== '0) begin
      err++;
      $display("FAIL %s: got a=%h/%b%b%b b=%h/%b%b%b c=%h/%b%b%b act=%b%b%b want all 0", name,
               byte_a, pe_a, fe_a, bk_a, byte_b, pe_b, fe_b, bk_b, byte_c, pe_c, fe_c, bk_c,
               act_a, act_b, act_c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 3'b111;
    repeat (4) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    idle(0, 2 * CPB);
  endtask

  task automatic test_basic();
    logic [15:0] lv;
    int n, lat;
    lv = mk_frame(0, 9'h0A5, 1'b0, 2'b11, n);
    frame_check("basic_A5", 0, lv, n, -1);
    lat = dv_cyc[0] - start_cyc;
    cmp++;
    if (lat !== 3 + 9 * CPB + M + 1) begin
      err++; $display("FAIL basic_latency: got %0d want %0d", lat, 3 + 9 * CPB + M + 1);
    end
    cmp++;
    if (byte_a !== 8'hA5) begin
      err++; $display("FAIL basic_byte: got %h want a5", byte_a);
    end
  endtask

  task automatic test_parity();
    logic [15:0] lv;
    int n;
    lv = mk_frame(1, 9'h041, 1'b1, 2'b11, n);
    frame_check("parity_bad", 1, lv, n, -1);
    cmp++;
    if ({pe_b, fe_b} !== 2'b10) begin
      err++; $display("FAIL parity_bad_flags: got pe=%b fe=%b want pe=1 fe=0", pe_b, fe_b);
    end
    lv = mk_frame(1, 9'h041, 1'b0, 2'b11, n);
    frame_check("parity_good", 1, lv, n, -1);
    cmp++;
    if (pe_b !== 1'b0) begin
      err++; $display("FAIL parity_good_flag: got pe=%b want 0", pe_b);
    end
  endtask

  task automatic test_false_start();
    logic [15:0] lv;
    int n, base;
    base = dv_cnt[0];
    @(negedge clk);
    rx[0] = 1'b0;
    start_cyc = cyc + 1;
    repeat (4) @(negedge clk);
    rx[0] = 1'b1;
    repeat (7) @(negedge clk);      // now at start_cyc + 10
    cmp++;
    if (act_a !== 1'b1) begin err++; $display("FAIL false_start_active_hi: got %b want 1", act_a); end
    @(negedge clk);
    cmp++;
    if (act_a !== 1'b0) begin err++; $display("FAIL false_start_active_lo: got %b want 0", act_a); end
    idle(0, 2 * CPB);
    cmp++;
    if (dv_cnt[0] !== base) begin
      err++; $display("FAIL false_start_dv: got %0d pulses want 0", dv_cnt[0] - base);
    end
    lv = mk_frame(0, 9'h03C, 1'b0, 2'b11, n);
    frame_check("after_false_3C", 0, lv, n, -1);
  endtask

  task automatic test_two_stop();
    logic [15:0] lv;
    int n;
    lv = mk_frame(2, 9'h0FF, 1'b0, 2'b01, n);
    frame_check("two_stop_err", 2, lv, n, -1);
    cmp++;
    if ({byte_c, fe_c, bk_c} !== {8'hFF, 1'b1, 1'b0}) begin
      err++; $display("FAIL two_stop_flags: got %h fe=%b brk=%b want ff fe=1 brk=0", byte_c, fe_c, bk_c);
    end
  endtask

  task automatic test_break();
    logic [15:0] lv;
    int n, base;
    base = dv_cnt[0];
    for (int c = 0; c < 30 * CPB; c++) begin @(negedge clk); rx[0] = 1'b0; end
    cmp++;
    if ({dv_cnt[0] - base, byte_a, fe_a, bk_a} !== {32'd1, 8'h00, 1'b1, 1'b1}) begin
      err++;
      $display("FAIL break_hold: got dv=%0d byte=%h fe=%b brk=%b want dv=1 byte=00 fe=1 brk=1",
               dv_cnt[0] - base, byte_a, fe_a, bk_a);
    end
    idle(0, 2 * CPB);
    cmp++;
    if (dv_cnt[0] - base !== 1) begin
      err++; $display("FAIL break_release_dv: got %0d want 1", dv_cnt[0] - base);
    end
    lv = mk_frame(0, 9'h05A, 1'b0, 2'b11, n);
    frame_check("after_break_5A", 0, lv, n, -1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] lv1, lv2, lv3;
    int n, base;
    lv1 = mk_frame(0, 9'h012, 1'b0, 2'b11, n);
    lv2 = mk_frame(0, 9'h034, 1'b0, 2'b11, n);
    lv3 = mk_frame(0, 9'h077, 1'b0, 2'b11, n);
    base = dv_cnt[0];
    send_frame(0, lv1, n, -1, 0);
    cmp++;
    if ({dv_cnt[0] - base, byte_a} !== {32'd1, 8'h12}) begin
      err++; $display("FAIL b2b_first: got dv=%0d byte=%h want dv=1 byte=12", dv_cnt[0] - base, byte_a);
    end
    frame_check("b2b_second_glitch", 0, lv2, n, 4);   // data bit 3 is wire bit 4
    cmp++;
    if (byte_a !== 8'h34) begin err++; $display("FAIL b2b_second_byte: got %h want 34", byte_a); end
    base = dv_cnt[0];
    send_frame(0, lv3, 4, -1, 0);
    cmp++;
    if (act_a !== 1'b1) begin err++; $display("FAIL abort_active: got %b want 1", act_a); end
    @(negedge clk);
    rst_n = 1'b0;
    rx[0] = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("abort_reset_outputs");
    rst_n = 1'b1;
    idle(0, 12 * CPB);
    cmp++;
    if (dv_cnt[0] !== base) begin
      err++; $display("FAIL abort_no_dv: got %0d pulses want 0", dv_cnt[0] - base);
    end
  endtask

  task automatic test_random();
    logic [15:0] lv;
    logic [8:0]  d;
    logic        pb;
    logic [1:0]  st;
    int n, sel;
    for (int k = 0; k < 18; k++) begin
      sel = k % 3;
      d   = 9'($urandom) & 9'((1 << nd_of(sel)) - 1);
      if ($urandom_range(0, 4) == 0) d = '0;
      pb  = 1'($urandom);
      st  = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      if (d == '0 && $urandom_range(0, 1) == 1) begin pb = 1'b0; st = 2'b00; end
      lv = mk_frame(sel, d, pb, st, n);
      frame_check($sformatf("random_%0d", k), sel, lv, n, -1);
    end
  endtask

  initial begin
    dv_cnt = '{0, 0, 0};
    dv_cyc = '{0, 0, 0};
    test_reset();
    test_basic();
    test_parity();
    test_false_start();
    test_two_stop();
    test_break();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
